// File: rtl/sram_axi_pkg.sv
// Shared types and constants for the AXI4-to-SRAM responder.
package sram_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WRITE = 3'd3,
    ST_WRESP = 3'd4
  } state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned BEAT_BYTES = 4;

endpackage

// File: rtl/sram_axi_addr_gen.sv
// Next-beat address and SRAM word index for the current burst address.
module sram_axi_addr_gen
  import sram_axi_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int SRAM_AW = 14
) (
  input  logic [ADDR_W-1:0]  addr,
  input  logic [1:0]         burst,
  output logic [ADDR_W-1:0]  next_addr,
  output logic [SRAM_AW-1:0] word_idx
);

  // WRAP and the reserved encoding step exactly like INCR.
  always_comb begin
    next_addr = addr + ADDR_W'(BEAT_BYTES);
    case (burst)
      BURST_FIXED:            next_addr = addr;
      BURST_INCR, BURST_WRAP: next_addr = addr + ADDR_W'(BEAT_BYTES);
      default:                next_addr = addr + ADDR_W'(BEAT_BYTES);
    endcase
  end

  // Index wraps naturally: upper address bits are simply dropped.
  assign word_idx = addr[SRAM_AW+1:2];

endmodule

// File: rtl/sram_axi_slave.sv
// AXI4 responder serving one read or write burst at a time from a 16K x 32 SRAM.
// Define SRAM_AXI_RANGE_CHECK_EN to answer SLVERR for bursts starting outside the window.
module sram_axi_slave
  import sram_axi_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                ID_W       = 8,
  parameter int                SRAM_AW    = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h0001_0000,
  parameter logic [ADDR_W-1:0] SIZE_BYTES = 32'h0001_0000
) (
  input  logic                clk,
  input  logic                rst,
  // write address
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [3:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  // write data
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  // write response
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  // read address
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [3:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  // read data
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready,
  // SRAM macro
  output logic                CEB,
  output logic [DATA_W/8-1:0] WEB,
  output logic                OE,
  output logic [SRAM_AW-1:0]  A,
  output logic [DATA_W-1:0]   DI,
  input  logic [DATA_W-1:0]   DO,
  // FSM observation
  output logic [2:0]          dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; once raised, every valid here is held with its payload
  // stable until that edge.

`ifdef SRAM_AXI_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  state_e              state, state_d;
  logic [ADDR_W-1:0]   addr, addr_d;
  logic [ID_W-1:0]     id, id_d;
  logic [3:0]          len, len_d;
  logic [3:0]          cnt, cnt_d;
  logic [1:0]          burst, burst_d;
  logic                err, err_d;
  logic [ADDR_W-1:0]   next_addr;
  logic [SRAM_AW-1:0]  word_idx;
  logic                ar_err, aw_err;
  logic                unused_bits;

  // Beats are always treated as 4 bytes; WLAST does not end a burst.
  assign unused_bits = ^{awsize, arsize, wlast};

  assign ar_err = RANGE_EN &&
                  !((araddr >= BASE_ADDR) && ((araddr - BASE_ADDR) < SIZE_BYTES));
  assign aw_err = RANGE_EN &&
                  !((awaddr >= BASE_ADDR) && ((awaddr - BASE_ADDR) < SIZE_BYTES));

  sram_axi_addr_gen #(
    .ADDR_W  (ADDR_W),
    .SRAM_AW (SRAM_AW)
  ) u_addr_gen (
    .addr      (addr),
    .burst     (burst),
    .next_addr (next_addr),
    .word_idx  (word_idx)
  );

  assign A         = word_idx;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      addr  <= '0;
      id    <= '0;
      len   <= '0;
      cnt   <= '0;
      burst <= BURST_FIXED;
      err   <= 1'b0;
    end else begin
      state <= state_d;
      addr  <= addr_d;
      id    <= id_d;
      len   <= len_d;
      cnt   <= cnt_d;
      burst <= burst_d;
      err   <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    addr_d  = addr;
    id_d    = id;
    len_d   = len;
    cnt_d   = cnt;
    burst_d = burst;
    err_d   = err;
    arready = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bid     = '0;
    bresp   = RESP_OKAY;
    rvalid  = 1'b0;
    rid     = '0;
    rdata   = '0;
    rresp   = RESP_OKAY;
    rlast   = 1'b0;
    CEB     = 1'b1;
    WEB     = '1;
    OE      = 1'b0;
    DI      = '0;

    case (state)
      ST_IDLE: begin
        // Reads take priority, so AW is refused whenever AR is offered.
        arready = 1'b1;
        awready = ~arvalid;
        if (arvalid) begin
          state_d = ST_RADDR;
          addr_d  = araddr;
          id_d    = arid;
          len_d   = arlen;
          burst_d = arburst;
          cnt_d   = '0;
          err_d   = ar_err;
        end else if (awvalid) begin
          state_d = ST_WRITE;
          addr_d  = awaddr;
          id_d    = awid;
          len_d   = awlen;
          burst_d = awburst;
          cnt_d   = '0;
          err_d   = aw_err;
        end
      end

      ST_RADDR: begin
        CEB     = err;
        OE      = 1'b1;
        state_d = ST_RDATA;
      end

      ST_RDATA: begin
        // CEB stays high here, so the macro keeps DO stable through a stall.
        OE     = 1'b1;
        rvalid = 1'b1;
        rid    = id;
        rdata  = err ? '0 : DO;
        rresp  = err ? RESP_SLVERR : RESP_OKAY;
        rlast  = (cnt == len);
        if (rready) begin
          if (cnt == len) begin
            state_d = ST_IDLE;
          end else begin
            addr_d  = next_addr;
            cnt_d   = cnt + 4'd1;
            state_d = ST_RADDR;
          end
        end
      end

      ST_WRITE: begin
        wready = 1'b1;
        if (wvalid) begin
          CEB    = 1'b0;
          WEB    = err ? '1 : ~wstrb;
          DI     = wdata;
          addr_d = next_addr;
          cnt_d  = cnt + 4'd1;
          if (cnt == len) begin
            state_d = ST_WRESP;
          end
        end
      end

      ST_WRESP: begin
        bvalid = 1'b1;
        bid    = id;
        bresp  = err ? RESP_SLVERR : RESP_OKAY;
        if (bready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_axi_slave.sv
// Randomised bench for sram_axi_slave against an array-based memory model.
module tb_sram_axi_slave;

  localparam int DEPTH = 16384;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr;
  logic [3:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, arvalid, arready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic        bvalid, bready, rlast, rvalid, rready;
  logic        CEB, OE;
  logic [3:0]  WEB;
  logic [13:0] A;
  logic [31:0] DI, DO;
  logic [2:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  int ceb_low  = 0;
  logic        mem_clear;
  logic [31:0] sram    [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_q   [$];
  logic [31:0] wq_data [$];
  logic [3:0]  wq_strb [$];
  time         t_ar, t_aw;

  always #5 clk = ~clk;

  sram_axi_slave dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .CEB(CEB), .WEB(WEB), .OE(OE), .A(A), .DI(DI), .DO(DO),
    .dbg_state(dbg_state)
  );

  // SRAM macro: byte-masked write, registered read output held while CEB=1.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= '0;
    end else if (!CEB) begin
      for (int b = 0; b < 4; b++)
        if (!WEB[b]) sram[A][8*b +: 8] <= DI[8*b +: 8];
      DO <= sram[A];
    end
  end

  always @(posedge clk) if (!CEB) ceb_low <= ceb_low + 1;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: word index, beat-to-beat address step, error window.
  function automatic int unsigned widx(input logic [31:0] a);
    return (a >> 2) % DEPTH;
  endfunction

  function automatic logic [31:0] nxt(input logic [31:0] a, input logic [1:0] b);
    return (b == 2'b00) ? a : a + 32'd4;
  endfunction

  function automatic bit is_err(input logic [31:0] a);
`ifdef SRAM_AXI_RANGE_CHECK_EN
    return !((a >= 32'h0001_0000) && (a < 32'h0002_0000));
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_idle_outputs();
    check("rst_state",   dbg_state, 3'd0);
    check("rst_arready", arready,   1'b1);
    check("rst_awready", awready,   1'b1);
    check("rst_wready",  wready,    1'b0);
    check("rst_valids",  {rvalid, bvalid}, 2'b00);
    check("rst_ceb",     CEB,       1'b1);
    check("rst_web",     WEB,       4'hF);
    check("rst_oe",      OE,        1'b0);
    check("rst_a",       A,         14'd0);
    check("rst_rdata",   rdata,     32'd0);
    check("rst_resp",    {rresp, bresp}, 4'd0);
    check("rst_ids",     {rid, bid}, 16'd0);
  endtask

  // Write burst; data/strobes come from wq_data/wq_strb.
  task automatic axi_write(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input bit expect_blocked);
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s, exp_web;
    bit          e;
    int          w;
    a = addr;
    e = is_err(addr);
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = 3'b010; awvalid = 1'b1;
    #1;
    if (expect_blocked) check("aw_blocked", awready, 1'b0);
    w = 0;
    while (!awready && w < 200) begin @(negedge clk); #1; w++; end
    if (!awready) begin check("aw_timeout", 0, 1); awvalid = 1'b0; return; end
    @(posedge clk); t_aw = $time; #1; awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      d = wq_data.pop_front();
      s = wq_strb.pop_front();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
      wvalid = 1'b1; wdata = d; wstrb = s; wlast = (i == int'(len));
      #1;
      w = 0;
      while (!wready && w < 50) begin @(negedge clk); #1; w++; end
      if (!wready) begin check("w_timeout", 0, 1); wvalid = 1'b0; return; end
      exp_web = e ? 4'hF : ~s;
      check("w_ceb",  CEB, 1'b0);
      check("w_web",  WEB, exp_web);
      check("w_addr", A,   widx(a));
      check("w_di",   DI,  d);
      if (!e)
        for (int b = 0; b < 4; b++)
          if (s[b]) ref_mem[widx(a)][8*b +: 8] = d[8*b +: 8];
      @(posedge clk); #1; wvalid = 1'b0;
      a = nxt(a, burst);
    end
    w = 0;
    @(negedge clk); #1;
    while (!bvalid && w < 50) begin @(negedge clk); #1; w++; end
    if (!bvalid) begin check("b_timeout", 0, 1); return; end
    check("b_id",   bid,   id);
    check("b_resp", bresp, e ? 2'b10 : 2'b00);
    repeat ($urandom_range(0, 2)) begin @(negedge clk); #1; check("b_hold", bvalid, 1'b1); end
    bready = 1'b1; @(posedge clk); #1; bready = 1'b0;
  endtask

  // Read burst; stall_mode 0 random, 1 alternating, 2 none. Stops after max_beats.
  task automatic axi_read(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input int stall_mode, input int max_beats);
    logic [31:0] a;
    logic [31:0] ex;
    bit          e;
    int          w, nb, stall;
    a = addr;
    e = is_err(addr);
    exp_q.delete();
    for (int i = 0; i <= int'(len); i++) begin
      exp_q.push_back(e ? 32'd0 : ref_mem[widx(a)]);
      a = nxt(a, burst);
    end
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arburst = burst; arsize = 3'b010; arvalid = 1'b1;
    #1;
    w = 0;
    while (!arready && w < 200) begin @(negedge clk); #1; w++; end
    if (!arready) begin check("ar_timeout", 0, 1); arvalid = 1'b0; return; end
    @(posedge clk); t_ar = $time; #1; arvalid = 1'b0;
    nb = (max_beats < int'(len) + 1) ? max_beats : int'(len) + 1;
    for (int i = 0; i < nb; i++) begin
      ex = exp_q.pop_front();
      w = 0;
      @(negedge clk); #1;
      while (!rvalid && w < 50) begin @(negedge clk); #1; w++; end
      if (!rvalid) begin check("r_timeout", 0, 1); return; end
      check("r_data", rdata, ex);
      check("r_id",   rid,   id);
      check("r_resp", rresp, e ? 2'b10 : 2'b00);
      check("r_last", rlast, i == int'(len));
      stall = (stall_mode == 1) ? 1 : (stall_mode == 0) ? $urandom_range(0, 2) : 0;
      repeat (stall) begin
        @(negedge clk); #1;
        check("r_stall_data",  rdata,  ex);
        check("r_stall_valid", rvalid, 1'b1);
      end
      rready = 1'b1; @(posedge clk); #1; rready = 1'b0;
    end
  endtask

  initial begin
    int          c0;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [1:0]  burst;
    rst = 1'b1; mem_clear = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'b010; awburst = '0; awvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'b010; arburst = '0; arvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1 mem_clear = 1'b0;
    @(negedge clk); #1;
    check_idle_outputs();
    @(negedge clk); rst = 1'b0;

    // INCR write then read-back with alternating RREADY
    for (int i = 0; i < 4; i++) begin wq_data.push_back(32'hA0 + i); wq_strb.push_back(4'hF); end
    axi_write(8'h12, 32'h0010_0040, 4'd3, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++)
      check("sram_word", sram[16 + i], is_err(32'h0010_0040) ? 32'd0 : 32'hA0 + i);
    axi_read(8'h34, 32'h0010_0040, 4'd3, 2'b01, 1, 16);

    // FIXED burst merging two half-word strobes into one word
    wq_data.push_back(32'hAABB_CCDD); wq_strb.push_back(4'b0011);
    wq_data.push_back(32'h1122_3344); wq_strb.push_back(4'b1100);
    axi_write(8'h05, 32'h0010_0000, 4'd1, 2'b00, 1'b0);
    check("fixed_merge", sram[0], is_err(32'h0010_0000) ? 32'd0 : 32'h1122_CCDD);
    axi_read(8'h06, 32'h0010_0000, 4'd0, 2'b01, 0, 16);

    // AR and AW together: read first, write held off until IDLE
    wq_data.push_back($urandom); wq_strb.push_back(4'hF);
    wq_data.push_back($urandom); wq_strb.push_back(4'hF);
    fork
      axi_read(8'h21, 32'h0001_0040, 4'd1, 2'b01, 0, 16);
      axi_write(8'h22, 32'h0001_0040, 4'd1, 2'b01, 1'b1);
    join
    check("rd_before_wr", t_ar < t_aw, 1'b1);
    axi_read(8'h23, 32'h0001_0040, 4'd1, 2'b01, 0, 16);

    // Reset after two beats of an 8-beat read
    axi_read(8'h44, 32'h0001_0100, 4'd7, 2'b01, 2, 2);
    @(negedge clk); rst = 1'b1; #1;
    check_idle_outputs();
    @(negedge clk); rst = 1'b0;
    axi_read(8'h45, 32'h0010_0040, 4'd3, 2'b01, 0, 16);

`ifdef SRAM_AXI_RANGE_CHECK_EN
    c0 = ceb_low;
    axi_read(8'h66, 32'h0002_0000, 4'd1, 2'b01, 0, 16);
    check("oor_ceb_low", ceb_low - c0, 0);
`else
    c0 = 0;
`endif

    // Random write/read pairs over all burst types, including index wrap
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       addr = $urandom & 32'hFFFF_FFFC;
        1:       addr = 32'h0001_FFF0;
        default: addr = 32'h0001_0000 + ($urandom_range(0, DEPTH - 1) << 2);
      endcase
      len   = 4'($urandom_range(0, 15));
      burst = 2'($urandom_range(0, 3));
      for (int i = 0; i <= int'(len); i++) begin
        wq_data.push_back($urandom);
        wq_strb.push_back(4'($urandom_range(0, 15)));
      end
      axi_write(8'($urandom), addr, len, burst, 1'b0);
      axi_read(8'($urandom), addr, len, burst, 0, 16);
      if ($urandom_range(0, 1) == 1)
        axi_read(8'($urandom), 32'h0001_0000 + ($urandom_range(0, 255) << 2),
                 4'($urandom_range(0, 15)), 2'b01, 0, 16);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_axi_slave.md
Name: sram_axi_slave

Overview:
AXI4 responder that serves bursts from the DMA master and the CPU masters on the bus.
- Sits behind the AXI interconnect and in front of a single-port SRAM macro (16K x 32).
- Converts one AXI read or write burst at a time into SRAM word accesses.
- Both the DMA copy path and the CPU load/store path terminate here.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, AXI data width, 4 byte lanes
ID_W, 8, slave-side AxID width (master ID extended by the interconnect)
SRAM_AW, 14, SRAM word-address width
BASE_ADDR, 32'h0001_0000, base address used by the range check
SIZE_BYTES, 32'h0001_0000, window size used by the range check

Ports:
clk  in  1  clock
rst  in  1  reset
slave  modport  AXI_slave_p.slave  AW/W/B/AR/R channels; AxLEN 4b, AxSIZE 3b, AxBURST 2b, xRESP 2b
CEB  out  1  SRAM chip enable, active low
WEB  out  4  SRAM per-byte write enable, active low
OE  out  1  SRAM output enable
A  out  SRAM_AW  SRAM word address
DI  out  32  SRAM write data
DO  in  32  SRAM read data, valid in the cycle after the address is issued, held while CEB=1

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: state=IDLE, all VALID outputs 0, WREADY 0, CEB 1, WEB 4'hF, OE 0, A 0, RDATA 0, RRESP/BRESP 2'b00, RID/BID 0. ARREADY/AWREADY decode from state; see IDLE.
- States: IDLE, RADDR, RDATA, WRITE, WRESP.
- IDLE:
  - ARREADY=1; AWREADY=~ARVALID.
  - Read wins on simultaneous ARVALID and AWVALID.
  - On handshake, latch ID, addr, LEN, BURST; beat counter=0.
  - AR handshake -> RADDR. AW handshake -> WRITE.
- RADDR (1 cycle): CEB=0, WEB=F, OE=1, A=addr[SRAM_AW+1:2] -> RDATA.
- RDATA:
  - RVALID=1, RDATA=DO, RID=latched ID, RLAST=(cnt==LEN). CEB=1 so DO holds; OE=1.
  - Hold all R outputs until RREADY.
  - On handshake: if RLAST -> IDLE; else advance addr, cnt++ -> RADDR.
  - Throughput: 1 beat per 2 cycles.
- WRITE:
  - WREADY=1.
  - Each accepted beat writes in the same cycle: CEB=0, WEB=~WSTRB, A=addr word, DI=WDATA. Advance addr, cnt++.
  - The burst ends on the beat with cnt==LEN; WLAST is ignored for termination. -> WRESP.
  - WVALID low: CEB=1, no write.
- WRESP: BVALID=1, BID=latched ID, BRESP=OKAY; held until BREADY -> IDLE.
- Address generation:
  - FIXED (2'b00): no increment.
  - INCR (2'b01): +4.
  - WRAP (2'b10) and reserved (2'b11): treated as INCR.
- AxSIZE: assumed 3'b010; other values are treated as 4-byte beats.
- SRAM index wraps modulo 2^SRAM_AW words; no boundary error.
- Outstanding transactions: one only. New AR/AW is never accepted before the current R/B completes.
- Reset mid-burst: immediate return to IDLE, no response emitted, SRAM idle.

Optional Feature:
SRAM_AXI_RANGE_CHECK_EN
- Defined:
  - Latched start addr outside [BASE_ADDR, BASE_ADDR+SIZE_BYTES) -> whole burst is SLVERR (2'b10).
  - Writes: all W beats are accepted with WEB forced 4'hF; BRESP=SLVERR.
  - Reads: RDATA=0, RRESP=SLVERR every beat, CEB stays 1.
  - Beat timing is unchanged.
- Undefined: no check; always OKAY.

Decomposition:
- Package sram_axi_pkg: state enum, BURST_FIXED/INCR/WRAP, RESP_OKAY/SLVERR constants, beat-size constant 4.
- One sub-module, sram_axi_addr_gen: combinational next address from addr/BURST, with word-index extraction.

Test Plan:
- Reset mid-read-burst (after 2 RDATA beats) -> outputs return to reset values; next AR is served normally.
- AW id=8'h12 addr=0x10_0040 LEN=3 INCR, WSTRB=F, data 0xA0..0xA3 -> SRAM words 0x10..0x13 written; BVALID with BID=8'h12, BRESP=0.
- AR same address, LEN=3, RREADY toggling 1/0 -> 4 beats 0xA0..0xA3 in order; RLAST only on 4th; RDATA stable while stalled.
- AW FIXED LEN=1 addr 0x10_0000, WSTRB 4'b0011 then 4'b1100 -> one word, WEB 4'b1100 then 4'b0011; readback merged value.
- ARVALID and AWVALID asserted in the same cycle -> read serviced first, AWREADY=0 until return to IDLE, then write completes.
- With SRAM_AXI_RANGE_CHECK_EN: AR addr 0x0002_0000 LEN=1 -> 2 beats RDATA=0, RRESP=2'b10, CEB never low.
